// File: rtl/pkt_fifo.sv
// Packet FIFO: bytes are staged behind a tentative pointer and only become visible to the
// reader once the whole packet commits; errored or overflowing packets are rolled back.
module pkt_fifo #(
  parameter int unsigned DATA_SIZE       = 8,
  parameter int unsigned PKT_LENGTH_BITS = 5,
  parameter int unsigned DEPTH           = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr_en,
  input  logic [DATA_SIZE-1:0] i_data_in,
  input  logic                 i_pkt_error,
  input  logic                 i_clr_errors,
  input  logic                 i_rd_en,
  output logic [DATA_SIZE-1:0] o_data_out,
  output logic                 o_data_valid,
  output logic                 o_rd_last,
  output logic                 o_pkt_avail,
  output logic                 o_full,
  output logic                 o_overflow
);

  localparam int unsigned PTR_BITS = $clog2(DEPTH);

  localparam logic [1:0] W_IDLE   = 2'd0;
  localparam logic [1:0] W_WRITE  = 2'd1;
  localparam logic [1:0] W_COMMIT = 2'd2;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_HDR  = 2'd1;
  localparam logic [1:0] R_BODY = 2'd2;

  localparam logic [PTR_BITS:0]        PTR_ONE = {{PTR_BITS{1'b0}}, 1'b1};
  localparam logic [PKT_LENGTH_BITS-1:0] REM_ONE = {{(PKT_LENGTH_BITS-1){1'b0}}, 1'b1};

  logic [DATA_SIZE-1:0] mem [DEPTH];

  logic [PTR_BITS:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS:0] tmp_ptr_q, tmp_ptr_d;
  logic [PTR_BITS:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_BITS:0] pkt_cnt_q, pkt_cnt_d;
  logic [PKT_LENGTH_BITS-1:0] rem_cnt_q, rem_cnt_d;
  logic [1:0] w_state_q, w_state_d;
  logic [1:0] r_state_q, r_state_d;
  logic refused_q, refused_d;
  logic overflow_q;
  logic [DATA_SIZE-1:0] data_out_q;
  logic data_valid_q, rd_last_q;

  logic full, empty, wr_ok, refuse, commit_ok, pop, last, last_pop;
  logic [DATA_SIZE-1:0] rd_byte;
  logic [PKT_LENGTH_BITS-1:0] head_len;

  // Full/empty by the classic extra-MSB compare; full counts staged (uncommitted) bytes too.
  assign full  = (tmp_ptr_q[PTR_BITS] != rd_ptr_q[PTR_BITS]) &&
                 (tmp_ptr_q[PTR_BITS-1:0] == rd_ptr_q[PTR_BITS-1:0]);
  assign empty = (rd_ptr_q == wr_ptr_q);

  assign wr_ok     = i_wr_en && (w_state_q != W_COMMIT) && !full;
  assign refuse    = i_wr_en && (w_state_q != W_COMMIT) && full;
  assign commit_ok = (w_state_q == W_COMMIT) && !i_pkt_error && !refused_q;

  assign rd_byte  = mem[rd_ptr_q[PTR_BITS-1:0]];
  assign head_len = rd_byte[3 +: PKT_LENGTH_BITS];
  assign pop      = i_rd_en && !empty && ((r_state_q == R_HDR) || (r_state_q == R_BODY));
  assign last     = (r_state_q == R_HDR) ? (head_len == '0) : (rem_cnt_q == REM_ONE);
  assign last_pop = pop && last;

  always_comb begin
    w_state_d = w_state_q;
    wr_ptr_d  = wr_ptr_q;
    tmp_ptr_d = tmp_ptr_q;
    refused_d = refused_q;
    case (w_state_q)
      W_IDLE:  if (i_wr_en) w_state_d = W_WRITE;
      W_WRITE: if (!i_wr_en) w_state_d = W_COMMIT;
      W_COMMIT: begin
        w_state_d = W_IDLE;
        refused_d = 1'b0;
        if (commit_ok) wr_ptr_d = tmp_ptr_q;
        else           tmp_ptr_d = wr_ptr_q;
      end
      default: w_state_d = W_IDLE;
    endcase
    if (wr_ok)  tmp_ptr_d = tmp_ptr_q + PTR_ONE;
    if (refuse) refused_d = 1'b1;
  end

  always_comb begin
    r_state_d = r_state_q;
    rem_cnt_d = rem_cnt_q;
    rd_ptr_d  = rd_ptr_q;
    case (r_state_q)
      R_IDLE: if (pkt_cnt_q != '0) r_state_d = R_HDR;
      R_HDR: if (pop) begin
        rem_cnt_d = head_len;
        r_state_d = last ? R_IDLE : R_BODY;
      end
      R_BODY: if (pop) begin
        rem_cnt_d = rem_cnt_q - REM_ONE;
        if (last) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // A commit and a last-byte pop in the same cycle cancel out.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (commit_ok && !last_pop)      pkt_cnt_d = pkt_cnt_q + PTR_ONE;
    else if (!commit_ok && last_pop) pkt_cnt_d = pkt_cnt_q - PTR_ONE;
  end

  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[tmp_ptr_q[PTR_BITS-1:0]] <= i_data_in;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q     <= '0;
      tmp_ptr_q    <= '0;
      rd_ptr_q     <= '0;
      pkt_cnt_q    <= '0;
      rem_cnt_q    <= '0;
      w_state_q    <= W_IDLE;
      r_state_q    <= R_IDLE;
      refused_q    <= 1'b0;
      overflow_q   <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      rd_last_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      tmp_ptr_q    <= tmp_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pkt_cnt_q    <= pkt_cnt_d;
      rem_cnt_q    <= rem_cnt_d;
      w_state_q    <= w_state_d;
      r_state_q    <= r_state_d;
      refused_q    <= refused_d;
      if (i_clr_errors) overflow_q <= 1'b0;
      else if (refuse)  overflow_q <= 1'b1;
      data_out_q   <= pop ? rd_byte : '0;
      data_valid_q <= pop;
      rd_last_q    <= last_pop;
    end
  end

  assign o_data_out   = data_out_q;
  assign o_data_valid = data_valid_q;
  assign o_rd_last    = rd_last_q;
  assign o_pkt_avail  = (pkt_cnt_q != '0);
  assign o_full       = full;
  assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_pkt_fifo.sv
// Directed and randomized bench for pkt_fifo; the reference model is a byte-level queue of
// committed packets plus an occupancy count.
module tb_pkt_fifo;

  localparam int DEPTH = 64;

  typedef logic [7:0] bq_t[$];

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] data_in;
  logic       pkt_error;
  logic       clr_errors;
  logic       rd_en;
  logic [7:0] data_out;
  logic       data_valid;
  logic       rd_last;
  logic       pkt_avail;
  logic       full;
  logic       overflow;

  pkt_fifo dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wr_en     (wr_en),
    .i_data_in   (data_in),
    .i_pkt_error (pkt_error),
    .i_clr_errors(clr_errors),
    .i_rd_en     (rd_en),
    .o_data_out  (data_out),
    .o_data_valid(data_valid),
    .o_rd_last   (rd_last),
    .o_pkt_avail (pkt_avail),
    .o_full      (full),
    .o_overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_fail = 0;
  logic [7:0] exp_b[$];
  logic [7:0] got_b[$];
  bit   exp_l[$];
  bit   got_l[$];
  int   gb = 0;
  int   eb = 0;
  int   committed = 0;
  int   popped = 0;
  int   full_cycles = 0;
  int   pkts_committed = 0;
  bit   rand_rd = 0;
  bit   ovf_exp = 0;

  always @(negedge clk) begin
    if (data_valid) begin
      got_b.push_back(data_out);
      got_l.push_back(rd_last);
      popped++;
    end
    if (full) full_cycles++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rd) rd_en = 1'($urandom_range(0, 1));
  endtask

  function automatic bq_t make_pkt(input int len, input int addr);
    bq_t q;
    logic [4:0] l;
    logic [2:0] a;
    l = len[4:0];
    a = addr[2:0];
    q.push_back({l, a});
    for (int i = 0; i < len; i++) q.push_back(8'($urandom_range(0, 255)));
    return q;
  endfunction

  // Writes one packet; the model commits it unless errored or it cannot fit.
  task automatic send(input bq_t b, input bit err, input bit pop_commit);
    bit drop;
    drop = ((committed - popped) + b.size() > DEPTH);
    foreach (b[i]) begin
      tick();
      wr_en   = 1'b1;
      data_in = b[i];
    end
    tick();
    wr_en     = 1'b0;
    data_in   = 8'h00;
    pkt_error = err;
    tick();
    if (pop_commit) rd_en = 1'b1;
    tick();
    pkt_error = 1'b0;
    if (pop_commit) rd_en = 1'b0;
    if (drop) ovf_exp = 1'b1;
    if (!err && !drop) begin
      committed += b.size();
      pkts_committed++;
      foreach (b[i]) begin
        exp_b.push_back(b[i]);
        exp_l.push_back(i == b.size() - 1);
      end
    end
  endtask

  task automatic sync_model();
    committed      = popped;
    pkts_committed = 0;
    gb             = got_b.size();
    eb             = exp_b.size();
    ovf_exp        = 1'b0;
  endtask

  task automatic do_reset();
    rand_rd = 0;
    wr_en = 0; data_in = 0; pkt_error = 0; clr_errors = 0; rd_en = 0;
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sync_model();
  endtask

  task automatic drain();
    rand_rd = 0;
    rd_en   = 1'b1;
    for (int i = 0; i < 4000 && (got_b.size() - gb) < (exp_b.size() - eb); i++) tick();
    repeat (12) tick();
    rd_en = 1'b0;
  endtask

  task automatic chk_stream(input string tag);
    int ng;
    int ne;
    ng = got_b.size() - gb;
    ne = exp_b.size() - eb;
    chk({tag, "_count"}, ng, ne);
    for (int i = 0; i < ne && i < ng; i++) begin
      chk({tag, "_byte"}, got_b[gb+i], exp_b[eb+i]);
      chk({tag, "_last"}, got_l[gb+i], exp_l[eb+i]);
    end
    gb = got_b.size();
    eb = exp_b.size();
  endtask

  initial begin
    bq_t pkt;
    int  fb;
    rst = 1'b1; wr_en = 0; data_in = 0; pkt_error = 0; clr_errors = 0; rd_en = 0;
    #1;
    chk("rst_valid", data_valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_last", rd_last, 0);
    chk("rst_avail", pkt_avail, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Basic 4-byte packet with exact timing.
    pkt = '{8'h19, 8'hAA, 8'hBB, 8'h08};
    foreach (pkt[i]) begin
      tick();
      wr_en   = 1'b1;
      data_in = pkt[i];
    end
    tick();
    wr_en = 1'b0;
    tick();
    chk("t1_avail_early", pkt_avail, 0);
    tick();
    chk("t1_avail", pkt_avail, 1);
    committed += 4;
    foreach (pkt[i]) begin
      exp_b.push_back(pkt[i]);
      exp_l.push_back(i == 3);
    end
    rd_en = 1'b1;
    tick();
    chk("t1_no_pop_idle", data_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_data", data_out, pkt[i]);
      chk("t1_valid", data_valid, 1);
      chk("t1_last", rd_last, (i == 3));
    end
    rd_en = 1'b0;
    tick();
    chk("t1_idle_valid", data_valid, 0);
    chk("t1_idle_data", data_out, 0);
    chk("t1_avail_after", pkt_avail, 0);
    chk_stream("t1");

    // Errored packet is rolled back.
    do_reset();
    send(pkt, 1'b1, 1'b0);
    chk("t2_avail", pkt_avail, 0);
    chk("t2_tmp_ptr", dut.tmp_ptr_q, 0);
    tick();
    tick();
    chk("t2_avail_late", pkt_avail, 0);

    // Overflow: 60 bytes committed, then an 8-byte packet that cannot fit.
    do_reset();
    for (int p = 0; p < 7; p++) send(make_pkt(7, p), 1'b0, 1'b0);
    send(make_pkt(3, 7), 1'b0, 1'b0);
    chk("t3_full_60", full, 0);
    chk("t3_ovf_60", overflow, 0);
    fb = full_cycles;
    send(make_pkt(7, 2), 1'b0, 1'b0);
    chk("t3_saw_full", (full_cycles > fb), 1);
    chk("t3_ovf", overflow, ovf_exp);
    chk("t3_full_after", full, ((committed - popped) == DEPTH));
    chk("t3_pkt_cnt", dut.pkt_cnt_q, pkts_committed);
    chk("t3_avail", pkt_avail, 1);
    clr_errors = 1'b1;
    tick();
    clr_errors = 1'b0;
    ovf_exp = 1'b0;
    chk("t3_ovf_clr", overflow, ovf_exp);
    drain();
    chk_stream("t3");
    chk("t3_avail_end", pkt_avail, 0);

    // Pointer wrap: 20 packets of 8 bytes, reader always enabled.
    do_reset();
    rd_en = 1'b1;
    fb = full_cycles;
    for (int p = 0; p < 20; p++) send(make_pkt(7, p), 1'b0, 1'b0);
    drain();
    chk("t4_never_full", full_cycles - fb, 0);
    chk_stream("t4");

    // Commit coinciding with a last-byte pop.
    do_reset();
    send(make_pkt(0, 1), 1'b0, 1'b0);
    send(make_pkt(0, 2), 1'b0, 1'b1);
    chk("t5_avail", pkt_avail, 1);
    chk("t5_pkt_cnt", dut.pkt_cnt_q, 1);
    drain();
    chk_stream("t5");
    chk("t5_avail_end", pkt_avail, 0);

    // Reset during a read and a partial write.
    do_reset();
    send(make_pkt(7, 3), 1'b0, 1'b0);
    rd_en = 1'b1;
    repeat (4) tick();
    wr_en   = 1'b1;
    data_in = 8'h5A;
    tick();
    tick();
    chk("t6_valid_pre", data_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", data_valid, 0);
    chk("t6_rst_data", data_out, 0);
    chk("t6_rst_last", rd_last, 0);
    chk("t6_rst_avail", pkt_avail, 0);
    chk("t6_rst_full", full, 0);
    chk("t6_rst_ovf", overflow, 0);
    wr_en = 1'b0;
    rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sync_model();
    rd_en = 1'b1;
    repeat (4) tick();
    rd_en = 1'b0;
    chk("t6_avail_after", pkt_avail, 0);
    chk("t6_valid_after", data_valid, 0);

    // Randomized traffic with a random reader; writes wait until the model says it fits.
    do_reset();
    rand_rd = 1;
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(0, 7);
      for (int w = 0; w < 1000 && (committed - popped) + len + 1 > DEPTH; w++) tick();
      send(make_pkt(len, p), ($urandom_range(0, 9) == 0), 1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();
    chk("t7_ovf", overflow, ovf_exp);
    chk_stream("t7");
    chk("t7_avail_end", pkt_avail, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
